// File: rtl/run_detect_pkg.sv
// run_detect_pkg: one-hot state encodings and bit indices for the run detector
package run_detect_pkg;
  localparam logic [4:0] ST_A = 5'b00001;
  localparam logic [4:0] ST_B = 5'b00010;
  localparam logic [4:0] ST_C = 5'b00100;
  localparam logic [4:0] ST_D = 5'b01000;
  localparam logic [4:0] ST_E = 5'b10000;
  localparam int IDX_A = 0;
  localparam int IDX_B = 1;
  localparam int IDX_C = 2;
  localparam int IDX_D = 3;
  localparam int IDX_E = 4;
  function automatic logic onehot5(input logic [4:0] v);
    return $countones(v) == 1;
  endfunction
endpackage

// File: rtl/run_detect_next.sv
// run_detect_next: combinational next-state logic of the one-hot run detector
module run_detect_next
  import run_detect_pkg::*;
(
  input  logic [4:0] cur,
  input  logic       w,
  output logic [4:0] nxt,
  output logic       z,
  output logic       illegal
);
  logic [4:0] c;
  always_comb begin
    illegal = ~onehot5(cur);
    c = illegal ? ST_A : cur;
    nxt[IDX_A] = 1'b0;
    nxt[IDX_B] = ~w & (c[IDX_A] | c[IDX_D] | c[IDX_E]);
    nxt[IDX_C] = ~w & (c[IDX_B] | c[IDX_C]);
    nxt[IDX_D] = w & (c[IDX_A] | c[IDX_B] | c[IDX_C]);
    nxt[IDX_E] = w & (c[IDX_D] | c[IDX_E]);
    z = nxt[IDX_C] | nxt[IDX_E];
  end
endmodule

// File: rtl/run_detect_sched.sv
// run_detect_sched: round-robin sharing of one run-detector engine across NCH streams
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_valid,
  input  logic [NCH-1:0] req_w,
  output logic [NCH-1:0] req_ready,
  input  logic [NCH-1:0] ch_clr,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic           out_z,
  output logic [4:0]     out_state,
  output logic           ctx_err
);
  logic [NCH-1:0][4:0] ctx;
  logic [CHW-1:0]      rr_ptr;
  logic [CHW-1:0]      gidx;
  logic [NCH-1:0]      elig;
  logic [NCH-1:0]      grant;
  logic                found;
  logic [4:0]          nxt;
  logic                z;
  logic                illegal;
  assign elig = req_valid & ~ch_clr;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < NCH; k++)
      if (!found && elig[(int'(rr_ptr) + k) % NCH]) begin
        found = 1'b1;
        gidx = CHW'((int'(rr_ptr) + k) % NCH);
      end
    grant = '0;
    grant[gidx] = found;
  end
  assign req_ready = rst ? grant : '0;
  run_detect_next u_next (
    .cur     (ctx[gidx]),
    .w       (req_w[gidx]),
    .nxt     (nxt),
    .z       (z),
    .illegal (illegal)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ctx <= {NCH{ST_A}};
      rr_ptr <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_z <= 1'b0;
      out_state <= ST_A;
      ctx_err <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (ch_clr[i]) ctx[i] <= ST_A;
      out_valid <= found;
      if (found) begin
        ctx[gidx] <= nxt;
        rr_ptr <= (gidx == CHW'(NCH - 1)) ? '0 : gidx + 1'b1;
        out_ch <= gidx;
        out_z <= z;
        out_state <= nxt;
        ctx_err <= ctx_err | illegal;
      end
    end
endmodule

// File: tb/tb_run_detect_sched.sv
// tb_run_detect_sched: directed stimulus with a queued scoreboard for run_detect_sched
module tb_run_detect_sched;
  import run_detect_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_w = '0;
  logic [3:0] ch_clr = '0;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [1:0] out_ch;
  logic       out_z;
  logic [4:0] out_state;
  logic       ctx_err;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [1:0] ch;
    logic [4:0] st;
    logic       z;
  } exp_t;
  exp_t q[$];
  run_detect_sched #(.NCH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_w     (req_w),
    .req_ready (req_ready),
    .ch_clr    (ch_clr),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_z     (out_z),
    .out_state (out_state),
    .ctx_err   (ctx_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got ch=%0d st=%b z=%b expected none", out_ch, out_state, out_z);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_ch !== e.ch || out_state !== e.st || out_z !== e.z) begin
          errors++;
          $display("FAIL result: got ch=%0d st=%b z=%b expected ch=%0d st=%b z=%b",
                   out_ch, out_state, out_z, e.ch, e.st, e.z);
        end
      end
    end
  task automatic step(input logic [3:0] v, input logic [3:0] w, input logic [3:0] clr,
                      input logic [3:0] rdy, input logic [4:0] st, input logic z);
    exp_t e;
    req_valid = v;
    req_w = w;
    ch_clr = clr;
    #1;
    chk("req_ready", int'(req_ready), int'(rdy));
    if (rdy != 4'b0) begin
      e.ch = 2'd0;
      for (int i = 0; i < 4; i++) if (rdy[i]) e.ch = 2'(i);
      e.st = st;
      e.z = z;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    req_w = '0;
    ch_clr = '0;
  endtask
  task automatic reset_checks();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_z", int'(out_z), 0);
    chk("rst_out_state", int'(out_state), int'(ST_A));
    chk("rst_ctx_err", int'(ctx_err), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    for (int i = 0; i < 4; i++) chk("rst_ctx", int'(dut.ctx[i]), int'(ST_A));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 rst = 1'b0;
    req_valid = 4'hF;
    #1 reset_checks();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // ch0 alone: w=0,0,1,1,1
    step(4'b0001, 4'b0000, 4'b0000, 4'b0001, ST_B, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 4'b0001, ST_C, 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, ST_D, 1'b0);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, ST_E, 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, ST_E, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    // all channels requesting: strict rotation from ch0
    step(4'b1111, 4'b1111, 4'b0000, 4'b0001, ST_D, 1'b0);
    step(4'b1111, 4'b1111, 4'b0000, 4'b0010, ST_D, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000, 4'b0100, ST_B, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000, 4'b1000, ST_B, 1'b0);
    step(4'b1111, 4'b1111, 4'b0000, 4'b0001, ST_E, 1'b1);
    step(4'b1111, 4'b0000, 4'b0000, 4'b0010, ST_B, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000, 4'b0100, ST_C, 1'b1);
    step(4'b1111, 4'b1111, 4'b0000, 4'b1000, ST_D, 1'b0);
    // clear on ch1 beats its request
    step(4'b0111, 4'b0000, 4'b0010, 4'b0001, ST_B, 1'b0);
    chk("ctx1_cleared", int'(dut.ctx[1]), int'(ST_A));
    step(4'b0111, 4'b0000, 4'b0010, 4'b0100, ST_C, 1'b1);
    step(4'b0010, 4'b0000, 4'b0000, 4'b0010, ST_B, 1'b0);
    chk("ctx_err_clean", int'(ctx_err), 0);
    // illegal context evaluates as A and latches ctx_err
    dut.ctx[3] = 5'b00110;
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, ST_D, 1'b0);
    chk("ctx_err_set", int'(ctx_err), 1);
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, ST_E, 1'b1);
    chk("ctx_err_sticky", int'(ctx_err), 1);
    @(negedge clk);
    #1 req_valid = 4'hF;
    rst = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b1;
    // alternate ch0 (w=1) and ch1 (w=0)
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, ST_D, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 4'b0010, ST_B, 1'b0);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, ST_E, 1'b1);
    step(4'b0010, 4'b0000, 4'b0000, 4'b0010, ST_C, 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, ST_E, 1'b1);
    step(4'b0010, 4'b0000, 4'b0000, 4'b0010, ST_C, 1'b1);
    chk("ctx0_final", int'(dut.ctx[0]), int'(ST_E));
    chk("ctx1_final", int'(dut.ctx[1]), int'(ST_C));
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, ST_A, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
